// File: rtl/decrypt_pipe_unscramble_shift_pkg.sv
// rtl/decrypt_pipe_unscramble_shift_pkg.sv - shared constants, types and helpers for the decrypt shift/scramble stage
package decrypt_config;

  // Forward bit permutation used by the encrypt side: scrambled[i] = plain[PERM_i]
  localparam int PERM_0 = 5;
  localparam int PERM_1 = 2;
  localparam int PERM_2 = 7;
  localparam int PERM_3 = 0;
  localparam int PERM_4 = 6;
  localparam int PERM_5 = 3;
  localparam int PERM_6 = 1;
  localparam int PERM_7 = 4;

  // Inverse mapping: INV_PERM_j is the i for which PERM_i == j, so plain[j] = scrambled[INV_PERM_j]
  localparam int INV_PERM_0 = 3;
  localparam int INV_PERM_1 = 6;
  localparam int INV_PERM_2 = 1;
  localparam int INV_PERM_3 = 5;
  localparam int INV_PERM_4 = 7;
  localparam int INV_PERM_5 = 0;
  localparam int INV_PERM_6 = 4;
  localparam int INV_PERM_7 = 2;

  localparam logic [7:0] UPPER_BASE = 8'd65;
  localparam logic [7:0] LOWER_BASE = 8'd97;
  localparam int         ALPHA_SIZE = 26;

  typedef enum logic [1:0] {
    CLS_OTHER,
    CLS_UPPER,
    CLS_LOWER
  } char_class_t;

  typedef struct packed {
    logic [7:0]  u;
    char_class_t cls;
    logic        shift_en;
    logic [3:0]  shift_amt;
  } s1_t;

  // Encrypt-direction permutation, used to build stimulus
  function automatic logic [7:0] scramble(input logic [7:0] p);
    scramble = {p[PERM_7], p[PERM_6], p[PERM_5], p[PERM_4],
                p[PERM_3], p[PERM_2], p[PERM_1], p[PERM_0]};
  endfunction

  // Undo the encrypt permutation
  function automatic logic [7:0] unscramble(input logic [7:0] d);
    unscramble = {d[INV_PERM_7], d[INV_PERM_6], d[INV_PERM_5], d[INV_PERM_4],
                  d[INV_PERM_3], d[INV_PERM_2], d[INV_PERM_1], d[INV_PERM_0]};
  endfunction

  // ASCII letter classification on the unscrambled byte
  function automatic char_class_t classify(input logic [7:0] u);
    if (u >= 8'd65 && u <= 8'd90) begin
      classify = CLS_UPPER;
    end else if (u >= 8'd97 && u <= 8'd122) begin
      classify = CLS_LOWER;
    end else begin
      classify = CLS_OTHER;
    end
  endfunction

endpackage

// File: rtl/decrypt_pipe_unscramble_shift_alpha_unrotate.sv
// rtl/decrypt_pipe_unscramble_shift_alpha_unrotate.sv - combinational inverse mod-26 rotation of a classified byte
module alpha_unrotate
  import decrypt_config::*;
#(
  parameter int ALPHA_SIZE = 26
) (
  input  logic [7:0]  i_u,
  input  char_class_t i_cls,
  input  logic        i_shift_en,
  input  logic [3:0]  i_amt,
  output logic [7:0]  o_data,
  output logic        o_rotated
);

  logic [7:0] w_base;
  logic [7:0] w_idx;
  logic [7:0] w_amt;
  logic [7:0] w_out_idx;
  logic       w_rotate;

  // Index arithmetic: subtract the shift and wrap by adding the alphabet size back when it underflows
  always_comb begin
    w_base    = (i_cls == CLS_UPPER) ? UPPER_BASE : LOWER_BASE;
    w_idx     = i_u - w_base;
    w_amt     = {4'd0, i_amt};
    w_rotate  = i_shift_en && (i_cls != CLS_OTHER);
    if (w_idx >= w_amt) begin
      w_out_idx = w_idx - w_amt;
    end else begin
      w_out_idx = w_idx + 8'(ALPHA_SIZE) - w_amt;
    end
    o_data    = w_rotate ? (w_base + w_out_idx) : i_u;
    o_rotated = w_rotate;
  end

endmodule

// File: rtl/decrypt_pipe_unscramble_shift.sv
// rtl/decrypt_pipe_unscramble_shift.sv - 2-stage elastic unscramble + inverse rotation pipe
module decrypt_pipe_unscramble_shift
  import decrypt_config::*;
#(
  parameter int ALPHA_SIZE = 26,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       din,
  input  logic             mode,
  input  logic             shift_en,
  input  logic [3:0]       shift_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       data_out,
  output logic [CNT_W-1:0] alpha_cnt
);

  s1_t              r_s1;
  logic             r_s1_valid;
  logic             r_s2_valid;
  logic [7:0]       r_s2_data;
  logic             r_s2_rot;
  logic [CNT_W-1:0] r_cnt;

  logic             w_s2_load_ok;
  logic             w_s1_adv;
  logic             w_in_xfer;
  logic             w_out_xfer;
  logic [7:0]       w_u;
  logic [7:0]       w_plain;
  logic             w_rot;
  s1_t              w_s1_next;

  // S2 frees up when empty or draining; S1 frees up when empty or moving into S2.
  // mode=1 closes the input side only, so in-flight bytes still drain.
  assign w_s2_load_ok = !r_s2_valid || out_ready;
  assign w_s1_adv     = r_s1_valid && w_s2_load_ok;
  assign in_ready     = !mode && (!r_s1_valid || w_s2_load_ok);
  assign w_in_xfer    = in_valid && in_ready;
  assign w_out_xfer   = r_s2_valid && out_ready;
  assign w_u          = unscramble(din);

  // Build the S1 payload from the incoming byte
  always_comb begin
    w_s1_next           = '0;
    w_s1_next.u         = w_u;
    w_s1_next.cls       = classify(w_u);
    w_s1_next.shift_en  = shift_en;
    w_s1_next.shift_amt = shift_amt;
  end

  alpha_unrotate #(
    .ALPHA_SIZE (ALPHA_SIZE)
  ) u_unrotate (
    .i_u        (r_s1.u),
    .i_cls      (r_s1.cls),
    .i_shift_en (r_s1.shift_en),
    .i_amt      (r_s1.shift_amt),
    .o_data     (w_plain),
    .o_rotated  (w_rot)
  );

  // Stage 1: capture unscrambled byte, class and shift controls on an input transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1       <= '0;
    end else if (w_in_xfer) begin
      r_s1_valid <= 1'b1;
      r_s1       <= w_s1_next;
    end else if (w_s1_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  // Stage 2: register the plaintext byte; holds steady while stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_data  <= 8'h00;
      r_s2_rot   <= 1'b0;
    end else if (w_s2_load_ok) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_data <= w_plain;
        r_s2_rot  <= w_rot;
      end
    end
  end

  // Count rotated letters as they leave the block, sticking at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_out_xfer && r_s2_rot && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign out_valid = r_s2_valid;
  assign data_out  = r_s2_data;
  assign alpha_cnt = r_cnt;

endmodule

// File: tb/tb_decrypt_pipe_unscramble_shift.sv
// tb/tb_decrypt_pipe_unscramble_shift.sv - scoreboard bench for the decrypt unscramble/shift pipe
module tb_decrypt_pipe_unscramble_shift;
  import decrypt_config::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  din;
  logic        mode;
  logic        shift_en;
  logic [3:0]  shift_amt;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  data_out;
  logic [15:0] alpha_cnt;

  always #5 clk = ~clk;

  decrypt_pipe_unscramble_shift #(
    .ALPHA_SIZE (26),
    .CNT_W      (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din       (din),
    .mode      (mode),
    .shift_en  (shift_en),
    .shift_amt (shift_amt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .alpha_cnt (alpha_cnt)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       rot;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] cur_plain;
  int         n_tests   = 0;
  int         n_fail    = 0;
  int         model_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic is_letter(input logic [7:0] p);
    return (p >= 8'd65 && p <= 8'd90) || (p >= 8'd97 && p <= 8'd122);
  endfunction

  function automatic logic [7:0] model_plain(input logic [7:0] p, input logic en, input logic [3:0] amt);
    int base;
    int idx;
    if (!en || !is_letter(p)) return p;
    base = (p <= 8'd90) ? 65 : 97;
    idx  = int'(p) - base;
    return 8'(base + ((idx - int'(amt) + 26) % 26));
  endfunction

  // Monitor: push on input transfer, pop and compare on output transfer
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (!rst) begin
      if (in_valid && in_ready) begin
        e.data = model_plain(cur_plain, shift_en, shift_amt);
        e.rot  = shift_en && is_letter(cur_plain);
        sb.push_back(e);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check_eq("sb_underflow", 32'(sb.size()), 1);
        end else begin
          e = sb.pop_front();
          check_eq("data_out", {24'd0, data_out}, {24'd0, e.data});
          if (e.rot && model_cnt != 65535) model_cnt++;
        end
      end
    end
  end

  task automatic drive(input logic [7:0] p, input logic en, input logic [3:0] amt);
    in_valid  = 1'b1;
    cur_plain = p;
    din       = scramble(p);
    shift_en  = en;
    shift_amt = amt;
  endtask

  task automatic send(input logic [7:0] p, input logic en, input logic [3:0] amt);
    int t;
    t = 0;
    @(negedge clk);
    drive(p, en, amt);
    #3;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      #3;
      t++;
    end
    if (!in_ready) check_eq("send_timeout", 32'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    #3;
    check_eq("drain_empty", 32'(sb.size()), 0);
  endtask

  logic [7:0] word [4];
  int         k;

  initial begin
    rst = 1'b1; in_valid = 1'b0; din = 8'h00; mode = 1'b0;
    shift_en = 1'b0; shift_amt = 4'd0; out_ready = 1'b1; cur_plain = 8'h00;
    #3;
    check_eq("rst_out_valid", 32'(out_valid), 0);
    check_eq("rst_data_out", {24'd0, data_out}, 0);
    check_eq("rst_alpha_cnt", {16'd0, alpha_cnt}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #3;
    check_eq("rst_in_ready", 32'(in_ready), 1);

    // Test 1: 'D' shift 3 -> 'A', two-cycle latency, single-cycle pulse
    @(negedge clk);
    drive(8'h44, 1'b1, 4'd3);
    #3;
    check_eq("t1_in_ready", 32'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
    #3;
    check_eq("t1_lat1_valid", 32'(out_valid), 0);
    @(negedge clk);
    #3;
    check_eq("t1_lat2_valid", 32'(out_valid), 1);
    check_eq("t1_data", {24'd0, data_out}, 32'h41);
    @(negedge clk);
    #3;
    check_eq("t1_pulse_end", 32'(out_valid), 0);
    check_eq("t1_cnt", {16'd0, alpha_cnt}, 1);

    // Test 2: wrap-around cases
    send(8'h62, 1'b1, 4'd5);
    send(8'h41, 1'b1, 4'd15);
    drain();
    check_eq("t2_cnt", {16'd0, alpha_cnt}, 32'(model_cnt));

    // Test 3: non-letters and shift disabled never rotate
    send(8'h20, 1'b1, 4'd7);
    send(8'h51, 1'b0, 4'd9);
    send(8'h00, 1'b1, 4'd9);
    send(8'h7F, 1'b1, 4'd9);
    send(8'h80, 1'b1, 4'd9);
    send(8'hFF, 1'b1, 4'd9);
    drain();
    check_eq("t3_cnt", {16'd0, alpha_cnt}, 3);

    // Round trip: every letter in both cases with every shift, streamed back-to-back
    for (int c = 0; c < 2; c++) begin
      for (int l = 0; l < 26; l++) begin
        for (int a = 0; a < 16; a++) begin
          @(negedge clk);
          drive(8'((c == 0 ? 65 : 97) + l), 1'b1, 4'(a));
        end
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    drain();
    check_eq("rt_cnt", {16'd0, alpha_cnt}, 32'(model_cnt));

    // Test 4: backpressure with a 3-cycle stall
    word[0] = 8'h4B; word[1] = 8'h45; word[2] = 8'h59; word[3] = 8'h53;
    k = 0;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      out_ready = (c >= 5);
      if (k < 4) drive(word[k], 1'b1, 4'd0);
      else in_valid = 1'b0;
      #3;
      if (c == 2) check_eq("t4_in_ready_low", 32'(in_ready), 0);
      if (c >= 2 && c <= 4) begin
        check_eq("t4_hold_valid", 32'(out_valid), 1);
        check_eq("t4_hold_data", {24'd0, data_out}, 32'h4B);
      end
      if (c >= 5) check_eq("t4_throughput", 32'(out_valid), 1);
      if (in_valid && in_ready) k++;
    end
    in_valid = 1'b0;
    drain();
    check_eq("t4_accepted", 32'(k), 4);

    // Test 5: mode goes idle with two bytes in flight
    @(negedge clk);
    drive(8'h6D, 1'b1, 4'd4);
    @(negedge clk);
    drive(8'h4E, 1'b0, 4'd2);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      mode = 1'b1;
      drive(8'h5A, 1'b1, 4'd1);
      #3;
      check_eq("t5_in_ready", 32'(in_ready), 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    mode = 1'b0;
    drain();
    repeat (2) begin
      @(negedge clk);
      #3;
      check_eq("t5_no_extra", 32'(out_valid), 0);
    end

    // Test 6: asynchronous reset with the pipe full and stalled
    out_ready = 1'b0;
    @(negedge clk);
    drive(8'h52, 1'b1, 4'd2);
    @(negedge clk);
    drive(8'h54, 1'b1, 4'd2);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    check_eq("t6_rst_valid", 32'(out_valid), 0);
    check_eq("t6_rst_data", {24'd0, data_out}, 0);
    check_eq("t6_rst_cnt", {16'd0, alpha_cnt}, 0);
    sb.delete();
    model_cnt = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      #3;
      check_eq("t6_no_stale", 32'(out_valid), 0);
    end

    // Saturation: more rotated letters than the counter can hold
    for (int i = 0; i < 70000; i++) begin
      @(negedge clk);
      drive(8'(97 + (i % 26)), 1'b1, 4'(i % 16));
    end
    @(negedge clk);
    in_valid = 1'b0;
    drain();
    check_eq("sat_cnt", {16'd0, alpha_cnt}, 32'hFFFF);
    check_eq("sat_model", {16'd0, alpha_cnt}, 32'(model_cnt));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/decrypt_pipe_unscramble_shift.md
Name: decrypt_pipe_unscramble_shift

Overview:
Decrypt-side counterpart of the encrypt shift/scramble pipe stage. It takes a scrambled ciphertext byte from the un-XOR stage and applies the inverse bit permutation. For letters, it then applies the inverse mod-26 alphabetic rotation and emits the plaintext byte. It is a 2-stage elastic pipeline with valid/ready handshakes and sits between the decrypt un-XOR stage and the output formatter.

Parameters:
ALPHA_SIZE, 26, alphabet length for rotation wrap
CNT_W, 16, width of the saturating decoded-letter counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
in_valid  in  1  input byte valid
in_ready  out  1  stage can accept input this cycle
din  in  8  scrambled ciphertext byte
mode  in  1  0 = decrypt active; 1 = block idle (encrypt direction)
shift_en  in  1  apply inverse rotation to letters
shift_amt  in  4  rotation amount (0..15), sampled with din
out_valid  out  1  plaintext byte valid
out_ready  in  1  downstream accepts byte
data_out  out  8  plaintext byte
alpha_cnt  out  CNT_W  number of letters decoded, saturating

Behaviour:
- Reset is asynchronous and active-high.
- Values while rst is high:
  - out_valid = 0
  - data_out = 8'h00
  - alpha_cnt = 0
  - all stage valids = 0
  - in_ready = 1 from the first cycle after release
- Transfers:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Stage 1 (S1) register, loaded on an input transfer:
  - u = inverse permutation of din, i.e. u[PERM_i] = din[i] for i = 0..7.
  - Class: upper if 65 <= u <= 90; lower if 97 <= u <= 122; else other.
  - Also latches shift_en and shift_amt.
- Stage 2 (S2) register, loaded from S1:
  - Letter with shift_en = 1: idx = u - base (base 65 or 97); out_idx = (idx - shift_amt) mod 26, computed as idx >= shift_amt ? idx - shift_amt : idx + 26 - shift_amt; data_out = base + out_idx.
  - Otherwise: data_out = u.
- Internal rotation uses index arithmetic, not a one-hot shift. All 26 letters and all shift_amt 0..15 round-trip exactly.
- Latency: 2 cycles from input transfer to out_valid with no backpressure. Throughput is 1 byte/cycle.
- Flow control:
  - S2 may load when !s2_valid || out_ready.
  - S1 may load when !s1_valid || S1 advances this cycle.
  - in_ready = !s1_valid || (!s2_valid || out_ready). It is combinational from out_ready.
- Stall: while out_valid && !out_ready, data_out and out_valid hold stable. At most 2 bytes are in flight and none are dropped or duplicated.
- Simultaneous load and drain in the same cycle on either stage is legal. The pipe stays full at one transfer per cycle.
- mode = 1:
  - in_ready = 0; new input is ignored.
  - Bytes already in flight drain normally.
  - Toggling mode mid-stream never corrupts in-flight bytes.
- alpha_cnt increments by 1 on each output transfer of a letter with shift_en = 1 (rotation applied) and saturates at all-ones.
- Reset mid-operation: all in-flight bytes are discarded. Outputs return to reset values asynchronously.
- Non-letter bytes, including 0x00, 0x7F and 0x80 to 0xFF, pass through unscrambled only and are never rotated.

Decomposition:
- Shared package decrypt_config, alongside encrypt_config, holds:
  - INV_PERM constants derived from the PERM_0..7 mapping.
  - Constants UPPER_BASE = 65, LOWER_BASE = 97, ALPHA_SIZE = 26.
  - Enum char_class_t {CLS_OTHER, CLS_UPPER, CLS_LOWER}.
  - Packed struct s1_t {u, cls, shift_en, shift_amt}.
  - Function scramble() for bench use.
- One sub-module is natural: alpha_unrotate (combinational u, cls, amt -> plaintext byte), reusable by the verification model.

Test Plan:
1. Reset, then scramble(8'h44 'D'), shift_en = 1, shift_amt = 3, out_ready = 1 -> 2 cycles later data_out = 8'h41 'A', out_valid pulses 1 cycle, alpha_cnt = 1.
2. Wrap: scramble('b'), shift_amt = 5 -> 'w' (8'h77). Also scramble('A'), shift_amt = 15 -> 'L' (8'h4C).
3. Non-letter pass-through: scramble(8'h20), shift_en = 1, shift_amt = 7 -> 8'h20, alpha_cnt unchanged. Also scramble('Q'), shift_en = 0 -> 'Q', alpha_cnt unchanged.
4. Backpressure: stream 'K','E','Y','S' (scrambled, amt = 0) with out_ready held low 3 cycles -> in_ready drops after 2 accepts, data_out holds 'K'. On release, the output is exactly K,E,Y,S in order with 1/cycle throughput.
5. mode = 1 asserted with 2 bytes in flight -> both emitted correctly, in_ready = 0, subsequent in_valid ignored.
6. Assert rst with the pipe full and out_ready = 0 -> out_valid = 0 and data_out = 0 immediately. After release no stale byte appears. Also drive 70000 rotated letters -> alpha_cnt saturates at 16'hFFFF.
